rca_fault_test_sequencer: RTL and testbench

Stimulus-side controller for single-fault testing of the ripple-carry adder. It steps the 3-bit test-vector index `count` through 0..7 and drives it to the adder inputs and the golden-value compare LUT. It waits a settle interval, then samples the LUT's 8-bit mismatch vector `comp`. It accumulates a fault map, a failing-vector count and the first failing index, and reports pass/fail through a start/busy/done handshake.

---
 rtl/rca_fault_test_sequencer.sv | 125 ++++++++++++
 tb/tb_rca_fault_test_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_fault_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rca_fault_test_sequencer
// Description : Steps the ripple-carry adder through its 8 test vectors,
//               samples the compare-LUT mismatch vector after a settle
//               interval, and accumulates fault map / count / first failure.
//               Optional macro HALT_ON_FAULT_EN stops the run at the first
//               failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_fault_test_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_VECTORS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] comp,
    output logic [2:0] count,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fault_map,
    output logic [3:0] fail_count,
    output logic       first_fail_valid,
    output logic [2:0] first_fail_count
);

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_RUN      = 1'b1;
    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] c_LAST_IDX    = 3'(NUM_VECTORS - 1);

    logic [0:0] r_state;
    logic [3:0] r_timer;
    logic [2:0] r_count;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_fault_map;
    logic [3:0] r_fail_count;
    logic       r_first_fail_valid;
    logic [2:0] r_first_fail_count;

    logic       w_sample_fail;
    logic [3:0] w_fail_count_nxt;
    logic       w_run_end;

    assign w_sample_fail    = |comp;
    assign w_fail_count_nxt = w_sample_fail ? (r_fail_count + 4'd1) : r_fail_count;

`ifdef HALT_ON_FAULT_EN
    assign w_run_end = (r_count == c_LAST_IDX) || w_sample_fail;
`else
    assign w_run_end = (r_count == c_LAST_IDX);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= c_ST_IDLE;
            r_timer            <= 4'd0;
            r_count            <= 3'd0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_fault_map        <= 8'd0;
            r_fail_count       <= 4'd0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_count <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_count <= 3'd0;
                    r_busy  <= 1'b0;
                    if (start) begin
                        r_fault_map        <= 8'd0;
                        r_fail_count       <= 4'd0;
                        r_first_fail_valid <= 1'b0;
                        r_first_fail_count <= 3'd0;
                        r_pass             <= 1'b0;
                        r_timer            <= c_SETTLE_LOAD;
                        r_busy             <= 1'b1;
                        r_state            <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (r_timer != 4'd0) begin
                        r_timer <= r_timer - 4'd1;
                    end else begin
                        // Sample edge: fold this vector's mismatch into the results.
                        r_fault_map  <= r_fault_map | comp;
                        r_fail_count <= w_fail_count_nxt;
                        if (w_sample_fail && !r_first_fail_valid) begin
                            r_first_fail_valid <= 1'b1;
                            r_first_fail_count <= r_count;
                        end
                        if (w_run_end) begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_count <= 3'd0;
                            r_pass  <= (w_fail_count_nxt == 4'd0);
                        end else begin
                            r_count <= r_count + 3'd1;
                            r_timer <= c_SETTLE_LOAD;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign count            = r_count;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign fault_map        = r_fault_map;
    assign fail_count       = r_fail_count;
    assign first_fail_valid = r_first_fail_valid;
    assign first_fail_count = r_first_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_rca_fault_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_fault_test_sequencer
// Description : Directed bench for rca_fault_test_sequencer with a result
//               scoreboard; instance A uses SETTLE_CYCLES=2, B uses 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_fault_test_sequencer;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic [7:0] comp_a, comp_b;
    logic [2:0] count_a, count_b;
    logic busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [7:0] fault_map_a, fault_map_b;
    logic [3:0] fail_count_a, fail_count_b;
    logic ffv_a, ffv_b;
    logic [2:0] ffc_a, ffc_b;

    logic [7:0] pat [8];
    assign comp_a = pat[count_a];
    assign comp_b = pat[count_b];

    rca_fault_test_sequencer #(.SETTLE_CYCLES(2), .NUM_VECTORS(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .comp(comp_a), .count(count_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fault_map(fault_map_a),
        .fail_count(fail_count_a), .first_fail_valid(ffv_a), .first_fail_count(ffc_a)
    );

    rca_fault_test_sequencer #(.SETTLE_CYCLES(1), .NUM_VECTORS(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .comp(comp_b), .count(count_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fault_map(fault_map_b),
        .fail_count(fail_count_b), .first_fail_valid(ffv_b), .first_fail_count(ffc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observation mux so one run task serves both instances.
    logic       sel;
    logic [2:0] s_count;
    logic       s_busy, s_done, s_pass, s_ffv;
    logic [7:0] s_fault_map;
    logic [3:0] s_fail_count;
    logic [2:0] s_ffc;
    assign s_count      = sel ? count_b      : count_a;
    assign s_busy       = sel ? busy_b       : busy_a;
    assign s_done       = sel ? done_b       : done_a;
    assign s_pass       = sel ? pass_b       : pass_a;
    assign s_fault_map  = sel ? fault_map_b  : fault_map_a;
    assign s_fail_count = sel ? fail_count_b : fail_count_a;
    assign s_ffv        = sel ? ffv_b        : ffv_a;
    assign s_ffc        = sel ? ffc_b        : ffc_a;

    typedef struct {
        logic [7:0] fm;
        logic [3:0] fc;
        logic       ffv;
        logic [2:0] ffc;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   start_pending = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic set_pat(input logic [63:0] v);
        for (int k = 0; k < 8; k++) pat[k] = v[8*k +: 8];
    endtask

    function automatic exp_t model(input int s);
        exp_t e;
        e.fm = 8'd0; e.fc = 4'd0; e.ffv = 1'b0; e.ffc = 3'd0; e.lat = 8 * s;
        for (int k = 0; k < 8; k++) begin
            e.fm = e.fm | pat[k];
            if (pat[k] != 8'd0) begin
                e.fc = e.fc + 4'd1;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.ffc = 3'(k);
                end
`ifdef HALT_ON_FAULT_EN
                e.lat = (k + 1) * s;
                break;
`endif
            end
        end
        e.pass = (e.fc == 4'd0);
        return e;
    endfunction

    task automatic run_seq(input int restart_at, input bit chain_next);
        exp_t e;
        int   s;
        int   c;
        s = sel ? 1 : 2;
        sb.push_back(model(s));
        if (!start_pending) begin
            @(negedge clk);
            drive_start(1'b1);
        end
        @(posedge clk); #1;
        drive_start(1'b0);
        start_pending = 0;
        chk("run_entry", {s_busy, s_done, s_pass, s_count}, {1'b1, 1'b0, 1'b0, 3'd0});
        for (c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (c == restart_at)          drive_start(1'b1);
            else if (c == restart_at + 1) drive_start(1'b0);
            if (s_done) break;
            chk("run_state", {s_busy, s_pass, s_count}, {1'b1, 1'b0, 3'(c / s)});
        end
        e = sb.pop_front();
        chk("done_latency", c, e.lat);
        chk("idle_at_done", {s_busy, s_count}, {1'b0, 3'd0});
        chk("fault_map", s_fault_map, e.fm);
        chk("fail_count", s_fail_count, e.fc);
        chk("first_fail_valid", s_ffv, e.ffv);
        chk("first_fail_count", s_ffc, e.ffc);
        chk("pass", s_pass, e.pass);
        if (chain_next) begin
            drive_start(1'b1);
            start_pending = 1;
        end else begin
            @(posedge clk); #1;
            chk("done_one_cycle", s_done, 1'b0);
            chk("results_hold", {s_fault_map, s_fail_count, s_pass}, {e.fm, e.fc, e.pass});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  w;
        bit  seen;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        set_pat(64'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {count_a, busy_a, done_a, pass_a, fault_map_a, fail_count_a, ffv_a, ffc_a}, 32'd0);
        chk("reset_b", {count_b, busy_b, done_b, pass_b, fault_map_b, fail_count_b, ffv_b, ffc_b}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Fault-free run, single fault, two faults, then clean rerun.
        run_seq(-1, 1'b0);
        set_pat(64'h0000_0000_0500_0000);
        run_seq(-1, 1'b0);
        set_pat(64'h0080_0000_0001_0000);
        run_seq(-1, 1'b0);
        set_pat(64'h0);
        run_seq(-1, 1'b0);

        // Start re-pulsed mid-run is ignored.
        run_seq(5, 1'b0);

        // Reset mid-run aborts without a done pulse.
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        for (w = 0; w < 100 && count_a != 3'd4; w++) begin
            @(posedge clk); #1;
        end
        chk("reached_count4", count_a, 3'd4);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_abort", {count_a, busy_a, done_a, pass_a, fault_map_a, fail_count_a, ffv_a, ffc_a}, 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_a) seen = 1;
        end
        chk("no_done_after_rst", seen, 1'b0);

        // Single fault at vector 3 (halts early when the option is built in).
        set_pat(64'h0000_0000_1000_0000);
        run_seq(-1, 1'b0);

        // SETTLE_CYCLES=1 instance: back-to-back runs with start in the done cycle.
        set_pat(64'h0);
        sel = 1'b1;
        run_seq(-1, 1'b1);
        run_seq(-1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
